// File: rtl/bira_pkg.sv
// Shared types for the BIST -> BIRA fault-report path: field widths, fault record, reporter FSM.
package bira_pkg;

  localparam int unsigned ROW_W  = 10;
  localparam int unsigned COL_W  = 10;
  localparam int unsigned BANK_W = 2;
  localparam int unsigned FLAG_W = 8;
  localparam int unsigned KEY_W  = ROW_W + COL_W + BANK_W;

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [BANK_W-1:0] bank;
    logic [FLAG_W-1:0] flag;
  } fault_rec_t;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, HALT} rep_state_t;

  // Location of a fault, ignoring which bits mismatched.
  function automatic logic [KEY_W-1:0] rec_key(input fault_rec_t r);
    return {r.row, r.col, r.bank};
  endfunction

endpackage

// File: rtl/bist_fault_reporter_fifo.sv
// Synchronous FIFO of fault records with flush and an OR-merge into the youngest entry.
module fault_fifo
  import bira_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  fault_rec_t             i_data,
  input  logic                   i_pop,
  input  logic                   i_merge,
  input  logic [FLAG_W-1:0]      i_merge_flag,
  output fault_rec_t             o_data,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  typedef logic [PTR_W:0] cnt_t;

  fault_rec_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [PTR_W-1:0] w_last_ptr;
  logic             w_push;
  logic             w_pop;

  assign w_push     = i_push && (r_count != cnt_t'(DEPTH));
  assign w_pop      = i_pop && (r_count != '0);
  assign w_last_ptr = r_wr_ptr - 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end else if (i_merge) begin
      r_mem[w_last_ptr].flag <= r_mem[w_last_ptr].flag | i_merge_flag;
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/bist_fault_reporter.sv
// Fault reporter toward BIRA: filters clean compares, queues faults, emits one per cycle.
// Optional FAULT_REPORTER_DEDUP_EN merges/drops repeated fault locations.
module bist_fault_reporter
  import bira_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmp_valid,
  output logic              o_cmp_ready,
  input  logic [ROW_W-1:0]  i_cmp_row,
  input  logic [COL_W-1:0]  i_cmp_col,
  input  logic [BANK_W-1:0] i_cmp_bank,
  input  logic [FLAG_W-1:0] i_cmp_mismatch,
  input  logic              i_march_done,
  input  logic              i_early_term,
  output logic              o_fault_detect,
  output logic [ROW_W-1:0]  o_row_add_out,
  output logic [COL_W-1:0]  o_col_add_out,
  output logic [FLAG_W-1:0] o_col_flag_out,
  output logic [BANK_W-1:0] o_bank_out,
  output logic              o_test_end,
  output logic              o_bist_halt,
  output logic [CNT_W-1:0]  o_fault_count
);

  localparam int unsigned FC_W = $clog2(FIFO_DEPTH) + 1;
  typedef logic [FC_W-1:0] fc_t;

  rep_state_t       r_state;
  logic             r_fault_detect;
  fault_rec_t       r_rec;
  logic             r_test_end;
  logic             r_bist_halt;
  logic [CNT_W-1:0] r_fault_count;

  fault_rec_t       w_in_rec;
  fault_rec_t       w_head;
  logic [FC_W-1:0]  w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_active;
  logic             w_accept;
  logic             w_faulty;
  logic             w_pop;
  logic             w_push;
  logic             w_merge;
  logic             w_flush;

  assign w_in_rec = {i_cmp_row, i_cmp_col, i_cmp_bank, i_cmp_mismatch};
  assign w_full   = (w_count == fc_t'(FIFO_DEPTH));
  assign w_empty  = (w_count == '0);
  assign w_active = (r_state == RUN) || (r_state == DRAIN);

  assign o_cmp_ready = (r_state == RUN) && !w_full;
  assign w_accept    = i_cmp_valid && o_cmp_ready;
  assign w_faulty    = |i_cmp_mismatch;
  // An abort suppresses the pop so nothing new reaches the outputs after it.
  assign w_pop       = w_active && !i_early_term && !w_empty;
  assign w_flush     = w_active && i_early_term;

`ifdef FAULT_REPORTER_DEDUP_EN
  logic [KEY_W-1:0] r_push_key;
  logic             r_push_vld;
  fault_rec_t       r_emit;
  logic             r_emit_vld;
  logic             w_tail_live;
  logic             w_dup;

  // The youngest entry is mergeable unless it is the only one and is leaving now.
  assign w_tail_live = !w_empty && !(w_pop && (w_count == fc_t'(1)));
  assign w_merge = w_accept && w_faulty && r_push_vld && w_tail_live &&
                   (rec_key(w_in_rec) == r_push_key);
  assign w_dup   = w_accept && w_faulty && !w_merge && r_emit_vld && (w_in_rec == r_emit);
  assign w_push  = w_accept && w_faulty && !w_merge && !w_dup;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_push_key <= '0;
      r_push_vld <= 1'b0;
      r_emit     <= '0;
      r_emit_vld <= 1'b0;
    end else begin
      if (w_flush) begin
        r_push_vld <= 1'b0;
      end else if (w_push) begin
        r_push_key <= rec_key(w_in_rec);
        r_push_vld <= 1'b1;
      end
      if (w_pop) begin
        r_emit     <= w_head;
        r_emit_vld <= 1'b1;
      end
    end
  end
`else
  assign w_merge = 1'b0;
  assign w_push  = w_accept && w_faulty;
`endif

  fault_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_flush      (w_flush),
    .i_push       (w_push),
    .i_data       (w_in_rec),
    .i_pop        (w_pop),
    .i_merge      (w_merge),
    .i_merge_flag (i_cmp_mismatch),
    .o_data       (w_head),
    .o_count      (w_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= IDLE;
      r_fault_detect <= 1'b0;
      r_rec          <= '0;
      r_test_end     <= 1'b0;
      r_bist_halt    <= 1'b0;
      r_fault_count  <= '0;
    end else begin
      r_fault_detect <= w_pop;
      r_rec          <= w_pop ? w_head : '0;
      if (w_pop && (r_fault_count != {CNT_W{1'b1}})) r_fault_count <= r_fault_count + 1'b1;
      case (r_state)
        IDLE: r_state <= RUN;
        RUN: begin
          if (i_early_term) begin
            r_state     <= HALT;
            r_bist_halt <= 1'b1;
          end else if (i_march_done) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (i_early_term) begin
            r_state     <= HALT;
            r_bist_halt <= 1'b1;
          end else if (w_empty) begin
            r_state <= DONE;
          end
        end
        DONE: r_test_end <= 1'b1;
        HALT: begin
          r_test_end  <= 1'b1;
          r_bist_halt <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_fault_detect = r_fault_detect;
  assign o_row_add_out  = r_rec.row;
  assign o_col_add_out  = r_rec.col;
  assign o_bank_out     = r_rec.bank;
  assign o_col_flag_out = r_rec.flag;
  assign o_test_end     = r_test_end;
  assign o_bist_halt    = r_bist_halt;
  assign o_fault_count  = r_fault_count;

endmodule
